// File: rtl/conv_job_scheduler.sv
// Queues convolution job descriptors and launches them one at a time on the conv controller.
// Optional watchdog: define JOB_TIMEOUT_EN to abort jobs stuck in WAIT_RUN/RUN after TIMEOUT_CYCLES.
module conv_job_scheduler #(
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH    = 32,
    parameter int unsigned DRAIN_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         arst_n_in,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [ID_WIDTH-1:0]          job_id,
    input  logic [COUNT_WIDTH-1:0]       job_expected,
    output logic                         ctrl_start,
    input  logic                         ctrl_running,
    input  logic                         ctrl_output_valid,
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic [ID_WIDTH-1:0]          done_id,
    output logic [COUNT_WIDTH-1:0]       done_count,
    output logic                         done_error,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
        DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("conv_job_scheduler: illegal parameter set");
    end

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [COUNT_WIDTH-1:0] expected;
    } job_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_RUN = 3'd2,
        RUN      = 3'd3,
        DRAIN    = 3'd4,
        REPORT   = 3'd5
    } state_e;

    job_t                   fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    state_e                 state_q, state_d;
    job_t                   job_q, job_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d, cnt_sat, cnt_next;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic                   err_q, err_d;
    logic                   push, pop;

    assign push = job_valid && job_ready;

    // Saturating pulse counter: holds at all-ones rather than wrapping.
    assign cnt_sat  = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
    assign cnt_next = ctrl_output_valid ? cnt_sat : count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {job_id, job_expected};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

`ifdef JOB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            wdog_hit;

    assign wdog_hit = (wdog_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        count_d = count_q;
        drain_d = drain_q;
        err_d   = err_q;
        pop     = 1'b0;
`ifdef JOB_TIMEOUT_EN
        wdog_d  = wdog_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    job_d   = fifo_mem[rd_ptr_q];
                    count_d = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_RUN;
`ifdef JOB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT_RUN: begin
                if (ctrl_running) begin
                    state_d = RUN;
                end
`ifdef JOB_TIMEOUT_EN
                wdog_d = wdog_q + TO_W'(1);
                if (wdog_hit) begin
                    state_d = REPORT;
                    err_d   = 1'b1;
                end
`endif
            end
            RUN: begin
                count_d = cnt_next;
                if (!ctrl_running) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
`ifdef JOB_TIMEOUT_EN
                wdog_d = wdog_q + TO_W'(1);
                if (wdog_hit) begin
                    state_d = REPORT;
                    err_d   = 1'b1;
                end
`endif
            end
            DRAIN: begin
                // Registered output_valid from the controller may land after running drops.
                count_d = cnt_next;
                if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = REPORT;
                    err_d   = (cnt_next != job_q.expected);
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            REPORT: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            job_q    <= '0;
            count_q  <= '0;
            drain_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            job_q    <= job_d;
            count_q  <= count_d;
            drain_q  <= drain_d;
            err_q    <= err_d;
        end
    end

    assign job_ready   = (level_q != LVL_W'(QUEUE_DEPTH));
    assign ctrl_start  = (state_q == LAUNCH);
    assign done_valid  = (state_q == REPORT);
    assign done_id     = job_q.id;
    assign done_count  = count_q;
    assign done_error  = err_q;
    assign busy        = (state_q != IDLE) || (level_q != '0);
    assign queue_level = level_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Bench for conv_job_scheduler: scripted controller, queue-level job model, per-cycle compare.
module tb_conv_job_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DRAIN = 1;
    localparam int unsigned TMO   = 20;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_id;
    logic [31:0] job_expected;
    logic        ctrl_start;
    logic        ctrl_running;
    logic        ctrl_output_valid;
    logic        done_valid;
    logic        done_ready;
    logic [7:0]  done_id;
    logic [31:0] done_count;
    logic        done_error;
    logic        busy;
    logic [2:0]  queue_level;

    always #5 clk = ~clk;

    conv_job_scheduler #(
        .QUEUE_DEPTH    (DEPTH),
        .ID_WIDTH       (8),
        .COUNT_WIDTH    (32),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .arst_n_in         (arst_n_in),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_id            (job_id),
        .job_expected      (job_expected),
        .ctrl_start        (ctrl_start),
        .ctrl_running      (ctrl_running),
        .ctrl_output_valid (ctrl_output_valid),
        .done_valid        (done_valid),
        .done_ready        (done_ready),
        .done_id           (done_id),
        .done_count        (done_count),
        .done_error        (done_error),
        .busy              (busy),
        .queue_level       (queue_level)
    );

    typedef struct {
        int          delay;
        int          run_len;
        logic [31:0] pulses;
    } script_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] expected;
    } job_t;

    int      checks   = 0;
    int      failures = 0;
    script_t scripts[$];
    job_t    m_fifo[$];
    job_t    m_cur;
    logic [7:0] done_log[$];
    int      m_level;
    bit      m_inflight, m_start, m_hold;
    logic    m_push, m_pop, m_hs;
    int      drv_count;
    bit      drv_timeout;
    int      n_starts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: FIFO of descriptors, at most one job in flight, one idle cycle after each handshake.
    assign m_push = job_valid && (m_level < int'(DEPTH));
    assign m_pop  = !m_inflight && (m_level > 0);
    assign m_hs   = m_inflight && done_valid && done_ready;

    always @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            m_level    <= 0;
            m_inflight <= 1'b0;
            m_start    <= 1'b0;
            m_hold     <= 1'b0;
            m_fifo.delete();
        end else begin
            m_start <= m_pop;
            m_hold  <= done_valid && !done_ready;
            if (m_pop) begin
                m_cur      <= m_fifo.pop_front();
                m_inflight <= 1'b1;
            end else if (m_hs) begin
                m_inflight <= 1'b0;
                done_log.push_back(done_id);
            end
            if (m_push) begin
                m_fifo.push_back('{job_id, job_expected});
            end
            m_level <= m_level + int'(m_push) - int'(m_pop);
        end
    end

    always @(negedge clk) begin
        check("job_ready", job_ready, m_level < int'(DEPTH));
        check("queue_level", queue_level, m_level);
        check("busy", busy, m_inflight || (m_level != 0));
        check("ctrl_start", ctrl_start, m_start);
        if (!m_inflight) begin
            check("done_valid_idle", done_valid, 1'b0);
        end else if (done_valid) begin
            check("done_id", done_id, m_cur.id);
            check("done_count", done_count, drv_count);
            check("done_error", done_error, drv_timeout || (32'(drv_count) != m_cur.expected));
        end
        if (m_hold) begin
            check("done_valid_hold", done_valid, 1'b1);
        end
    end

    // Controller model: sample k is taken at the edge closing the k-th cycle after ctrl_start.
    // Pulses count when the scheduler is in RUN/DRAIN: after the sample that sees running rise,
    // up to DRAIN samples after the first low sample.
    initial begin : ctrl_model
        script_t s;
        ctrl_running      = 1'b0;
        ctrl_output_valid = 1'b0;
        drv_count         = 0;
        drv_timeout       = 1'b0;
        forever begin
            @(negedge clk);
            while (arst_n_in && ctrl_start) begin
                n_starts++;
                check("start_has_script", scripts.size() != 0, 1'b1);
                if (scripts.size() != 0) s = scripts.pop_front();
                else s = '{1, 1, 32'h0};
                drv_count = 0;
                for (int k = 0; k < 32; k++) begin
                    if (s.pulses[5'(k)] && k > s.delay && k <= s.delay + s.run_len + int'(DRAIN))
                        drv_count++;
                end
                drv_timeout = 1'b0;
`ifdef JOB_TIMEOUT_EN
                if (s.run_len == 0) drv_timeout = 1'b1;
`endif
                for (int k = 0; k < s.delay + s.run_len + int'(DRAIN) + 3 && k < 32 && arst_n_in; k++) begin
                    ctrl_running      = (k >= s.delay) && (k < s.delay + s.run_len);
                    ctrl_output_valid = s.pulses[5'(k)];
                    @(negedge clk);
                end
                ctrl_running      = 1'b0;
                ctrl_output_valid = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_job(input logic [7:0] id, input logic [31:0] exp_cnt, input int max_wait);
        int n;
        n = 0;
        job_valid    = 1'b1;
        job_id       = id;
        job_expected = exp_cnt;
        while (!job_ready && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) check("push_wait", job_ready, 1'b1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (!done_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", done_valid, 1'b1);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    initial begin : main
        int g, c, starts0;
        arst_n_in    = 1'b0;
        job_valid    = 1'b0;
        job_id       = 8'h00;
        job_expected = 32'h0;
        done_ready   = 1'b1;
        tick(3);
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_queue_level", queue_level, 3'd0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_ctrl_start", ctrl_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done_count", done_count, 32'd0);
        check("rst_done_id", done_id, 8'h00);
        check("rst_done_error", done_error, 1'b0);
        arst_n_in = 1'b1;
        tick(2);

        // Single job, last pulse lands in the drain cycle.
        scripts.push_back('{2, 10, 32'h0000_2490});
        starts0 = n_starts;
        push_job(8'h05, 32'd4, 10);
        wait_done(40);
        check("t1_id", done_id, 8'h05);
        check("t1_count", done_count, 32'd4);
        check("t1_error", done_error, 1'b0);
        check("t1_starts", n_starts - starts0, 1);
        wait_idle(10);

        // Short count; pulses in WAIT_RUN and after REPORT are ignored.
        scripts.push_back('{1, 4, 32'h0000_014A});
        push_job(8'h11, 32'd3, 10);
        wait_done(40);
        check("t3_model_count", drv_count, 2);
        check("t3_id", done_id, 8'h11);
        check("t3_count", done_count, 32'd2);
        check("t3_error", done_error, 1'b1);
        wait_idle(10);

        // Record held in REPORT for 7 cycles with a job waiting behind it.
        done_ready = 1'b0;
        scripts.push_back('{1, 3, 32'h0});
        scripts.push_back('{1, 2, 32'h4});
        push_job(8'h22, 32'd0, 10);
        push_job(8'h23, 32'd1, 10);
        wait_done(40);
        check("t4_id", done_id, 8'h22);
        check("t4_count", done_count, 32'd0);
        check("t4_error", done_error, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("t4_hold_valid", done_valid, 1'b1);
            check("t4_hold_id", done_id, 8'h22);
            check("t4_hold_start", ctrl_start, 1'b0);
        end
        done_ready = 1'b1;
        g = 0;
        while (g < 10) begin
            tick(1);
            g++;
            if (ctrl_start) break;
        end
        check("t4_restart_gap", g, 2);
        wait_done(40);
        check("t4b_id", done_id, 8'h23);
        check("t4b_count", done_count, 32'd1);
        wait_idle(10);

        // Queue fills behind a long-running job; fifth push waits for the first pop.
        done_log.delete();
        scripts.push_back('{1, 14, 32'h0});
        for (int i = 0; i < 5; i++) scripts.push_back('{1, 2, 32'h4});
        push_job(8'h30, 32'd0, 10);
        tick(3);
        for (int i = 1; i <= 4; i++) push_job(8'(8'h30 + i), 32'd1, 10);
        check("t2_level_full", queue_level, 3'd4);
        check("t2_ready_full", job_ready, 1'b0);
        push_job(8'h35, 32'd1, 60);
        wait_idle(200);
        check("t2_done_n", done_log.size(), 6);
        for (int i = 0; i < done_log.size() && i < 6; i++) begin
            check("t2_order", done_log[i], 8'(8'h30 + i));
        end

        // Reset while running with two jobs queued.
        done_log.delete();
        scripts.push_back('{1, 10, 32'h0});
        scripts.push_back('{1, 2, 32'h0});
        scripts.push_back('{1, 2, 32'h0});
        push_job(8'h40, 32'd0, 10);
        push_job(8'h41, 32'd0, 10);
        push_job(8'h42, 32'd0, 10);
        tick(2);
        check("t5_level_before", queue_level, 3'd2);
        check("t5_busy_before", busy, 1'b1);
        arst_n_in = 1'b0;
        #1;
        check("t5_rst_ready", job_ready, 1'b1);
        check("t5_rst_level", queue_level, 3'd0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_valid", done_valid, 1'b0);
        check("t5_rst_start", ctrl_start, 1'b0);
        check("t5_rst_count", done_count, 32'd0);
        scripts.delete();
        starts0 = n_starts;
        tick(2);
        arst_n_in = 1'b1;
        tick(30);
        check("t5_no_record", done_log.size(), 0);
        check("t5_no_start", n_starts - starts0, 0);
        check("t5_idle", busy, 1'b0);

`ifdef JOB_TIMEOUT_EN
        // Controller never raises running; watchdog forces an error record.
        scripts.push_back('{1, 0, 32'h0});
        push_job(8'h50, 32'd5, 10);
        g = 0;
        while (!ctrl_start && g < 10) begin
            tick(1);
            g++;
        end
        check("t6_started", ctrl_start, 1'b1);
        c = 0;
        while (!done_valid && c < 100) begin
            tick(1);
            c++;
        end
        check("t6_latency", c, TMO + 1);
        check("t6_id", done_id, 8'h50);
        check("t6_count", done_count, 32'd0);
        check("t6_error", done_error, 1'b1);
        wait_idle(10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL tb_timeout: simulation exceeded its time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
